sram_access_ctrl: RTL and testbench
===================================

# sram_access_ctrl

Multi-cycle controller between the MEM stage and a 16-bit-wide external SRAM. It turns a single-cycle 32-bit load/store request from the MEM stage into two sequenced half-word SRAM accesses, and holds `ready` low so the pipeline registers freeze until the word is complete. It sits beside the data-memory path. `rdata` feeds the MEM/WB pipeline register's memory-data input, and `ready` gates the enables of every upstream pipeline register.

## Interface
- `WAIT_CYCLES`, default 1: extra SRAM wait cycles per half-word phase. Phase length PHASE = WAIT_CYCLES+1 cycles; legal range 0..7.
- `ADDR_BASE`, default 1024: byte address mapped to SRAM word 0.
- Reset: rst, asynchronous, active-high. Clock: clk.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `MEM_r_en`  in  1  load request from the MEM stage; held stable while `ready`=0.
- `MEM_w_en`  in  1  store request; held stable while `ready`=0.
- `address`  in  32  byte address (ALU result).
- `wdata`  in  32  store data.
- `rdata`  out  32  load result. Valid while `ready`=1 after a load; holds its value otherwise.
- `ready`  out  1  0 = freeze the pipeline.
- `sram_addr`  out  18  half-word address.
- `sram_we_n`  out  1  active-low write strobe.
- `sram_dq_out`  out  16  write data to the pad.
- `sram_dq_oe`  out  1  1 = drive the pad with `sram_dq_out`.
- `sram_dq_in`  in  16  read data from the pad.

## Operation
- Request: `req` = `MEM_r_en` | `MEM_w_en`. If both are set, the access is a write. `is_wr` is latched at request acceptance.
- Word index = (`address` − `ADDR_BASE`) >> 2, truncated to 17 bits, so it wraps modulo 2^17. There is no range check.
- `sram_addr` = {word_idx, 1'b0} in LOW; {word_idx, 1'b1} in HIGH. The low half-word is stored at the even address.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: on a clock edge with `req`=1, latch word_idx, `wdata` and `is_wr`, load the phase counter with WAIT_CYCLES, and go to LOW. With `req`=0, stay in IDLE.
  - LOW / HIGH: the counter decrements every cycle. On the cycle where the counter = 0, a read captures `sram_dq_in` into rdata[15:0] (LOW) or rdata[31:16] (HIGH). At the following edge, LOW goes to HIGH (counter reloaded) and HIGH goes to DONE.
  - DONE: `ready`=1 for exactly one cycle, then IDLE unconditionally.
- Write: `sram_we_n`=0 and `sram_dq_oe`=1 for all cycles of LOW and HIGH. `sram_dq_out` = wdata_q[15:0] in LOW and wdata_q[31:16] in HIGH. A write does not modify `rdata`.
- Read: `sram_we_n`=1 and `sram_dq_oe`=0 in every state.
- `ready` (combinational) = (state==IDLE & ~`req`) | (state==DONE).
- Outside LOW and HIGH: `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr` and `sram_dq_out` hold their last values.

## Timing
- Reset values: state=IDLE, `rdata`=0, `sram_addr`=0, `sram_we_n`=1, `sram_dq_oe`=0, `sram_dq_out`=0, counter=0. During reset, `ready` = ~`req`.
- Reset mid-access: abort at once and return to IDLE. The SRAM strobe deasserts asynchronously, so no partial write continues past rst rising. `rdata` returns to 0.
- Stall length: `ready` is low for 1 + 2·PHASE cycles, counted from the first cycle `req` is seen in IDLE. It is then high for the single DONE cycle.
  - WAIT_CYCLES=1: 5 cycles low, high on the 6th.
  - WAIT_CYCLES=0: 3 cycles low, high on the 4th.
- The pipeline advances at the edge that ends DONE. The next IDLE cycle sees the next instruction, so back-to-back accesses pay the full stall each time with no overlap.
- `rdata` is stable from the DONE cycle until the next read completes its LOW capture.
- A request that deasserts mid-access violates protocol. The access still completes, and `ready` rises in DONE.

## Test plan
- Load, WAIT_CYCLES=1, `address`=1024+8. SRAM model returns 0x1234 at half-word 4 and 0xABCD at half-word 5.
  - `ready` is low for 5 cycles; `sram_addr` = 4 then 5.
  - `rdata` = 0xABCD1234 in DONE.
- Store, `address`=1024+12, `wdata`=0xDEADBEEF.
  - `sram_we_n`=0 for 4 cycles.
  - Model holds 0xBEEF at half-word 6 and 0xDEAD at half-word 7.
  - `rdata` is unchanged.
- Back-to-back store then load to the same address.
  - Two separate stalls: 5 low, 1 high, 5 low, 1 high.
  - The load returns the stored word.
- Both `MEM_r_en` and `MEM_w_en` set: the access is performed as a write, and `sram_dq_oe`=1 in LOW and HIGH.
- Reset in the 2nd cycle of a write.
  - `sram_we_n`=1 and `sram_dq_oe`=0 immediately.
  - After release with `req`=0: `ready`=1 and state is IDLE.
  - Half-word 7 is unchanged.
- WAIT_CYCLES=0 build, load at `ADDR_BASE`: `ready` is low for 3 cycles. Idle with no request keeps `ready`=1 and `sram_we_n`=1 indefinitely.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// Sequences one 32-bit MEM-stage load/store into two half-word accesses on a
// 16-bit asynchronous SRAM, freezing the pipeline via `ready` until done.
module sram_access_ctrl #(
  parameter int          WAIT_CYCLES = 1,
  parameter int unsigned ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_r_en,
  input  logic        MEM_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [2:0]  RELOAD  = 3'(WAIT_CYCLES);
  localparam logic [18:0] BASE_LO = 19'(ADDR_BASE);

  state_t      state;
  logic [2:0]  cnt;
  logic [15:0] wdata_hi_q;
  logic        is_wr;

  logic        req;
  logic [18:0] offset;
  logic [16:0] word_idx;
  logic        unused_addr_bits;

  assign req = MEM_r_en | MEM_w_en;

  // Only the low 19 bits of the subtraction reach the 17-bit word index, so
  // the upper address bits drop out and the index wraps modulo 2^17.
  assign offset           = address[18:0] - BASE_LO;
  assign word_idx         = offset[18:2];
  assign unused_addr_bits = ^{address[31:19], offset[1:0]};

  assign ready = ((state == IDLE) && !req) || (state == DONE);

  // NOTE: asynchronous reset drops the write strobe and output enable the
  // moment rst rises, so an interrupted store never finishes a half-word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wdata_hi_q  <= '0;
      is_wr       <= 1'b0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // sees the pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (req) begin
            state       <= LOW;
            cnt         <= RELOAD;
            is_wr       <= MEM_w_en;
            wdata_hi_q  <= wdata[31:16];
            sram_addr   <= {word_idx, 1'b0};
            sram_dq_out <= wdata[15:0];
            sram_we_n   <= ~MEM_w_en;
            sram_dq_oe  <= MEM_w_en;
          end
        end
        LOW: begin
          if (cnt == 3'd0) begin
            if (!is_wr) rdata[15:0] <= sram_dq_in;
            state        <= HIGH;
            cnt          <= RELOAD;
            sram_addr[0] <= 1'b1;
            sram_dq_out  <= wdata_hi_q;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        HIGH: begin
          if (cnt == 3'd0) begin
            if (!is_wr) rdata[31:16] <= sram_dq_in;
            state      <= DONE;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench: directed and random loads/stores against a word-level
// reference memory, plus reset-abort and WAIT_CYCLES=0 stall checks.
module tb_sram_access_ctrl;

  localparam int PH  = 2;  // phase length of the main instance (WAIT_CYCLES=1)
  localparam int HWN = 262144;

  logic        clk, rst;
  logic        MEM_r_en, MEM_w_en;
  logic [31:0] address, wdata, rdata;
  logic        ready, sram_we_n, sram_dq_oe;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  logic        r0, w0;
  logic [31:0] addr0, wd0, rdata0;
  logic        ready0, we_n0, oe0;
  logic [17:0] sram_addr0;
  logic [15:0] dq_out0, dq_in0;

  logic [15:0] sram [HWN];  // device contents
  logic [15:0] gold [HWN];  // reference contents
  logic [31:0] exp_rdata;
  int          total, passed, fails;

  sram_access_ctrl #(.WAIT_CYCLES(1), .ADDR_BASE(1024)) dut (
    .clk(clk), .rst(rst), .MEM_r_en(MEM_r_en), .MEM_w_en(MEM_w_en),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in));

  sram_access_ctrl #(.WAIT_CYCLES(0), .ADDR_BASE(1024)) dut0 (
    .clk(clk), .rst(rst), .MEM_r_en(r0), .MEM_w_en(w0),
    .address(addr0), .wdata(wd0), .rdata(rdata0), .ready(ready0),
    .sram_addr(sram_addr0), .sram_we_n(we_n0), .sram_dq_out(dq_out0),
    .sram_dq_oe(oe0), .sram_dq_in(dq_in0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM device: combinational read, write while strobe is low.
  assign sram_dq_in = sram[sram_addr];
  assign dq_in0     = sram[sram_addr0];
  always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=1 instance; reference computed from the
  // address map and stall formula, then checked after the DONE cycle.
  task automatic do_access(input logic r, input logic w, input logic [31:0] addr,
                           input logic [31:0] wd);
    int          low, we_cnt, oe_cnt;
    logic [17:0] a_lo, a_hi, hw;
    logic [15:0] d_lo, d_hi;
    logic [31:0] word;
    word = (addr - 32'd1024) >> 2;
    hw   = {word[16:0], 1'b0};
    @(negedge clk);
    MEM_r_en = r; MEM_w_en = w; address = addr; wdata = wd;
    #1;
    low = 0; we_cnt = 0; oe_cnt = 0; a_lo = 'x; a_hi = 'x; d_lo = 'x; d_hi = 'x;
    while (!ready && low < 40) begin
      if (low == 1)      begin a_lo = sram_addr; d_lo = sram_dq_out; end
      if (low == 1 + PH) begin a_hi = sram_addr; d_hi = sram_dq_out; end
      if (!sram_we_n) we_cnt++;
      if (sram_dq_oe) oe_cnt++;
      low++;
      @(negedge clk); #1;
    end
    if (w) begin
      gold[hw]     = wd[15:0];
      gold[hw + 1] = wd[31:16];
    end else begin
      exp_rdata = {gold[hw + 1], gold[hw]};
    end
    check("stall_cycles", low, 1 + 2 * PH);
    check("addr_low", 32'(a_lo), 32'(hw));
    check("addr_high", 32'(a_hi), 32'(hw) + 1);
    check("we_cycles", we_cnt, w ? 2 * PH : 0);
    check("oe_cycles", oe_cnt, w ? 2 * PH : 0);
    if (w) begin
      check("dq_out_low", 32'(d_lo), 32'(wd[15:0]));
      check("dq_out_high", 32'(d_hi), 32'(wd[31:16]));
    end
    check("done_ready", 32'(ready), 1);
    check("rdata", rdata, exp_rdata);
    check("mem_low", 32'(sram[hw]), 32'(gold[hw]));
    check("mem_high", 32'(sram[hw + 1]), 32'(gold[hw + 1]));
    MEM_r_en = 1'b0; MEM_w_en = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int          low;
    total = 0; passed = 0; fails = 0; exp_rdata = '0;
    rst = 1'b1;
    MEM_r_en = 0; MEM_w_en = 0; address = '0; wdata = '0;
    r0 = 0; w0 = 0; addr0 = '0; wd0 = '0;
    for (int i = 0; i < HWN; i++) begin
      v = $urandom;
      sram[i] = v[15:0];
      gold[i] = v[15:0];
    end
    sram[4] = 16'h1234; gold[4] = 16'h1234;
    sram[5] = 16'hABCD; gold[5] = 16'hABCD;

    #1;
    check("rst_ready", 32'(ready), 1);
    check("rst_rdata", rdata, 0);
    check("rst_sram_addr", 32'(sram_addr), 0);
    check("rst_we_n", 32'(sram_we_n), 1);
    check("rst_oe", 32'(sram_dq_oe), 0);
    check("rst_dq_out", 32'(sram_dq_out), 0);
    check("rst_dq_out0", 32'(dq_out0), 0);
    MEM_r_en = 1'b1; #1;
    check("rst_ready_req", 32'(ready), 0);
    MEM_r_en = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    do_access(1'b1, 1'b0, 32'd1032, 32'h0);
    check("load_const", rdata, 32'hABCD1234);

    do_access(1'b0, 1'b1, 32'd1036, 32'hDEADBEEF);
    check("store_hw6", 32'(sram[6]), 32'h0000BEEF);
    check("store_hw7", 32'(sram[7]), 32'h0000DEAD);
    check("store_keeps_rdata", rdata, 32'hABCD1234);

    v = $urandom;
    do_access(1'b0, 1'b1, 32'd1044, v);
    do_access(1'b1, 1'b0, 32'd1044, 32'h0);
    check("b2b_load_sees_store", rdata, v);

    do_access(1'b1, 1'b1, 32'd1048, $urandom);   // both enables: a write
    do_access(1'b1, 1'b0, 32'd1020, 32'h0);      // wraps to word 0x1FFFF

    for (int i = 0; i < 16; i++) begin
      v = $urandom_range(0, 2);
      do_access(v != 0, v != 1, $urandom, $urandom);
    end

    // Reset during the second cycle of a store to half-words 6/7.
    @(negedge clk);
    MEM_w_en = 1'b1; address = 32'd1036; wdata = 32'h01234567;
    @(negedge clk); #1;
    check("pre_rst_we_n", 32'(sram_we_n), 0);
    rst = 1'b1; #1;
    check("abort_we_n", 32'(sram_we_n), 1);
    check("abort_oe", 32'(sram_dq_oe), 0);
    check("abort_rdata", rdata, 0);
    exp_rdata = '0;
    MEM_w_en = 1'b0;
    @(negedge clk);
    rst = 1'b0; #1;
    check("post_rst_ready", 32'(ready), 1);
    @(negedge clk); #1;
    check("post_rst_idle_ready", 32'(ready), 1);
    check("abort_hw6", 32'(sram[6]), 32'(gold[6]));
    check("abort_hw7", 32'(sram[7]), 32'(gold[7]));

    // WAIT_CYCLES=0 instance: load at the base address.
    @(negedge clk);
    r0 = 1'b1; addr0 = 32'd1024; #1;
    low = 0;
    while (!ready0 && low < 40) begin
      low++;
      @(negedge clk); #1;
    end
    check("w0_stall_cycles", low, 3);
    check("w0_rdata", rdata0, {gold[1], gold[0]});
    r0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      check("w0_idle_ready", 32'(ready0), 1);
      check("w0_idle_we_n", 32'(we_n0), 1);
      check("w0_idle_oe", 32'(oe0), 0);
      check("idle_we_n", 32'(sram_we_n), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
